// File: rtl/hex_scroll_ctrl.sv
// Auto-scrolling glyph ring driven onto DIGITS active-low 7-segment displays.
// Prescaler-timed or manual stepping in either direction, with a runtime-writable message ring.
module hex_scroll_ctrl #(
    parameter int DIGITS  = 8,
    parameter int MSG_LEN = 8,
    parameter int CLK_HZ  = 50_000_000,
    parameter int STEP_HZ = 2
) (
    input  logic                                          CLOCK_50,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic                                          dir,
    input  logic                                          step,
    input  logic                                          load,
    input  logic [3:0]                                    wr_addr,
    input  logic [7:0]                                    wr_data,
    output logic [8*DIGITS-1:0]                           hex_out,
    output logic [$clog2(MSG_LEN > 1 ? MSG_LEN : 2)-1:0]  pos,
    output logic                                          wrap
);

    localparam int PW  = $clog2(MSG_LEN > 1 ? MSG_LEN : 2);
    localparam int DIV = CLK_HZ / STEP_HZ;
    localparam int CW  = $clog2(DIV);
    localparam logic [PW-1:0] LAST_POS = PW'(MSG_LEN - 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DIV - 1);

    logic [CW-1:0]       cnt_r;
    logic                tick_s;
    logic                adv_s;
    logic [PW-1:0]       pos_r;
    logic [PW-1:0]       pos_nxt_s;
    logic                wrap_r;
    logic [7:0]          ring_r [MSG_LEN];
    logic [8*DIGITS-1:0] view_s;
    logic [8*DIGITS-1:0] hex_r;

    // Power-up message "HELLO" followed by blanks.
    function automatic logic [7:0] default_glyph(input logic [4:0] idx);
        case (idx)
            5'd0:    return 8'h89;
            5'd1:    return 8'h86;
            5'd2:    return 8'hC7;
            5'd3:    return 8'hC7;
            5'd4:    return 8'hC0;
            default: return 8'hFF;
        endcase
    endfunction

    // (p + off) mod MSG_LEN; both operands are below MSG_LEN so one subtract suffices.
    function automatic logic [PW-1:0] ring_index(input logic [PW-1:0] p, input int off);
        logic [4:0] s;
        s = 5'(p) + 5'(off);
        if (s >= 5'(MSG_LEN)) begin
            s = s - 5'(MSG_LEN);
        end else begin
            s = s;
        end
        return s[PW-1:0];
    endfunction

    assign tick_s = en & (cnt_r == CNT_MAX);
    assign adv_s  = step | tick_s;

    // Prescaler: free-runs only while enabled, holding its count otherwise.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (en) begin
            cnt_r <= (cnt_r == CNT_MAX) ? '0 : cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Next ring offset; a coincident step and tick collapse into one advance.
    always_comb begin
        pos_nxt_s = pos_r;
        if (adv_s) begin
            if (dir) begin
                pos_nxt_s = (pos_r == '0) ? LAST_POS : pos_r - PW'(1);
            end else begin
                pos_nxt_s = (pos_r == LAST_POS) ? '0 : pos_r + PW'(1);
            end
        end else begin
            pos_nxt_s = pos_r;
        end
    end

    // Offset register and wrap pulse on entry into offset 0 from elsewhere.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            pos_r  <= '0;
            wrap_r <= 1'b0;
        end else begin
            pos_r  <= pos_nxt_s;
            wrap_r <= adv_s & (pos_nxt_s == '0) & (pos_r != '0);
        end
    end

    // Message ring: reset restores defaults, out-of-range addresses match no entry.
    always_ff @(posedge CLOCK_50) begin
        for (int k = 0; k < MSG_LEN; k++) begin
            if (rst) begin
                ring_r[k] <= default_glyph(5'(k));
            end else if (load && (wr_addr == 4'(k))) begin
                ring_r[k] <= wr_data;
            end else begin
                ring_r[k] <= ring_r[k];
            end
        end
    end

    // Window of the ring starting at pos, leftmost digit first.
    always_comb begin
        view_s = '1;
        for (int i = 0; i < DIGITS; i++) begin
            view_s[8*i +: 8] = ring_r[ring_index(pos_r, DIGITS - 1 - i)];
        end
    end

    // Display register: blank while in reset.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            hex_r <= '1;
        end else begin
            hex_r <= view_s;
        end
    end

    assign hex_out = hex_r;
    assign pos     = pos_r;
    assign wrap    = wrap_r;

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl: directed scenarios plus random traffic, each cycle checked
// against an arithmetic model of the scrolling message ring.
module tb_hex_scroll_ctrl;

    localparam int DIGITS  = 8;
    localparam int MSG_LEN = 8;
    localparam int DIV     = 10;

    logic        CLOCK_50 = 1'b0;
    logic        rst      = 1'b1;
    logic        en       = 1'b0;
    logic        dir      = 1'b0;
    logic        step     = 1'b0;
    logic        load     = 1'b0;
    logic [3:0]  wr_addr  = 4'd0;
    logic [7:0]  wr_data  = 8'd0;
    logic [63:0] hex_out;
    logic [2:0]  pos;
    logic        wrap;

    int total = 0;
    int bad   = 0;

    int          m_pos;
    int          m_cnt;
    logic [7:0]  m_ring [MSG_LEN];
    logic [63:0] m_hex;
    logic        m_wrap;

    hex_scroll_ctrl #(
        .DIGITS (DIGITS),
        .MSG_LEN(MSG_LEN),
        .CLK_HZ (10),
        .STEP_HZ(1)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .rst     (rst),
        .en      (en),
        .dir     (dir),
        .step    (step),
        .load    (load),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .hex_out (hex_out),
        .pos     (pos),
        .wrap    (wrap)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge, applied from the inputs currently driven.
    task automatic model_edge();
        bit tk;
        int np;
        if (rst) begin
            m_pos  = 0;
            m_cnt  = 0;
            m_wrap = 1'b0;
            m_hex  = '1;
            m_ring = '{8'h89, 8'h86, 8'hC7, 8'hC7, 8'hC0, 8'hFF, 8'hFF, 8'hFF};
        end else begin
            tk = en && (m_cnt == DIV - 1);
            if (en) m_cnt = (m_cnt + 1) % DIV;
            for (int i = 0; i < DIGITS; i++)
                m_hex[8*i +: 8] = m_ring[(m_pos + DIGITS - 1 - i) % MSG_LEN];
            np = m_pos;
            if (step || tk)
                np = dir ? (m_pos + MSG_LEN - 1) % MSG_LEN : (m_pos + 1) % MSG_LEN;
            m_wrap = (step || tk) && (np == 0) && (m_pos != 0);
            m_pos  = np;
            if (load && (int'(wr_addr) < MSG_LEN)) m_ring[wr_addr] = wr_data;
        end
    endtask

    task automatic cyc();
        model_edge();
        @(posedge CLOCK_50);
        #1;
        check("pos",  64'(pos),  64'(m_pos));
        check("wrap", 64'(wrap), 64'(m_wrap));
        check("hex",  hex_out,   m_hex);
    endtask

    initial begin
        int          wraps;
        int          n;
        int          guard;
        logic [2:0]  p0;
        logic [63:0] snap;

        // 1: reset and default view
        rst = 1'b1;
        cyc();
        check("rst_hex0", hex_out, 64'hFFFF_FFFF_FFFF_FFFF);
        cyc();
        check("rst_hex1", hex_out, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b0;
        cyc();
        check("default_view", hex_out, 64'h8986_C7C7_C0FF_FFFF);
        check("default_pos", 64'(pos), 64'd0);

        // 2: auto-scroll left over one full ring revolution
        en = 1'b1; dir = 1'b0;
        wraps = 0;
        repeat (10) begin cyc(); wraps += int'(wrap); end
        check("first_tick_pos", 64'(pos), 64'd1);
        cyc(); wraps += int'(wrap);
        check("first_step_view", hex_out, 64'h86C7_C7C0_FFFF_FF89);
        repeat (69) begin cyc(); wraps += int'(wrap); end
        check("auto_wrap_count", 64'(wraps), 64'd1);
        check("auto_end_pos", 64'(pos), 64'd0);

        // 3: manual step right through the wrap boundary
        en = 1'b0; dir = 1'b1;
        step = 1'b1; cyc(); step = 1'b0;
        check("right_pos7", 64'(pos), 64'd7);
        check("right_no_wrap", 64'(wrap), 64'd0);
        cyc();
        check("right_view", hex_out, 64'hFF89_86C7_C7C0_FFFF);
        check("right_hex7", 64'(hex_out[63:56]), 64'hFF);
        step = 1'b1; cyc(); step = 1'b0;
        check("right_pos6", 64'(pos), 64'd6);

        // 4: step coinciding with tick, then a 5-cycle enable gap
        en = 1'b1; dir = 1'b0;
        repeat (9) cyc();
        check("pre_coinc_pos", 64'(pos), 64'd6);
        step = 1'b1; cyc(); step = 1'b0;
        check("coinc_single_adv", 64'(pos), 64'd7);
        p0 = pos; n = 0;
        repeat (4) begin cyc(); n++; end
        en = 1'b0;
        repeat (5) begin cyc(); n++; end
        en = 1'b1;
        while (pos == p0 && n < 40) begin cyc(); n++; end
        check("gap_tick_delay", 64'(n), 64'd15);

        // 5: ring writes
        en = 1'b0; dir = 1'b0; guard = 0;
        while (pos != 3'd0 && guard < 20) begin step = 1'b1; cyc(); step = 1'b0; guard++; end
        check("load_start_pos", 64'(pos), 64'd0);
        load = 1'b1; wr_addr = 4'd5; wr_data = 8'hA4;
        cyc(); load = 1'b0;
        cyc();
        check("load_hex2", 64'(hex_out[23:16]), 64'hA4);
        snap = hex_out;
        load = 1'b1; wr_addr = 4'd12; wr_data = 8'h00;
        cyc(); load = 1'b0;
        cyc();
        check("load_oor_hex", hex_out, snap);
        check("load_oor_pos", 64'(pos), 64'd0);
        load = 1'b1; wr_addr = 4'd7; wr_data = 8'h92; step = 1'b1;
        cyc(); load = 1'b0; step = 1'b0;
        check("load_step_pos", 64'(pos), 64'd1);
        cyc();
        check("load_step_hex1", 64'(hex_out[15:8]), 64'h92);

        // random traffic against the model
        for (int r = 0; r < 300; r++) begin
            en      = 1'($urandom_range(0, 1));
            dir     = 1'($urandom_range(0, 1));
            step    = ($urandom_range(0, 3) == 0);
            load    = ($urandom_range(0, 2) == 0);
            wr_addr = 4'($urandom_range(0, 15));
            wr_data = 8'($urandom);
            rst     = ($urandom_range(0, 99) == 0);
            cyc();
        end
        rst = 1'b0; en = 1'b0; dir = 1'b0; step = 1'b0; load = 1'b0;
        cyc();

        // 6: reset in the middle of operation
        load = 1'b1; wr_addr = 4'd0; wr_data = 8'h11; cyc();
        wr_addr = 4'd3; wr_data = 8'h22; cyc();
        load = 1'b0; guard = 0;
        while (pos != 3'd3 && guard < 20) begin step = 1'b1; cyc(); step = 1'b0; guard++; end
        check("midop_pos3", 64'(pos), 64'd3);
        rst = 1'b1; load = 1'b1; wr_addr = 4'd1; wr_data = 8'h33;
        cyc();
        load = 1'b0;
        check("midop_rst_pos", 64'(pos), 64'd0);
        check("midop_rst_hex", hex_out, 64'hFFFF_FFFF_FFFF_FFFF);
        rst = 1'b0;
        cyc();
        check("midop_default_view", hex_out, 64'h8986_C7C7_C0FF_FFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
